// File: rtl/fifo_buffer.sv
// fifo_buffer: synchronous FIFO with arbitrary depth, occupancy count, thresholds, flush and sticky errors.
module fifo_buffer #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 13,
    parameter int DEPTH        = 4900,
    parameter int AFULL_LEVEL  = 4800,
    parameter int AEMPTY_LEVEL = 100
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);
    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_CNT   = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AE_CNT   = (ADDR_WIDTH+1)'(AEMPTY_LEVEL);
    localparam logic [ADDR_WIDTH-1:0] LAST     = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  pop_ok, push_ok;

    assign empty        = count == '0;
    assign full         = count == FULL_CNT;
    assign almost_full  = count >= AF_CNT;
    assign almost_empty = count <= AE_CNT;
    assign pop_ok       = pop && !empty;
    assign push_ok      = push && (!full || pop_ok);

    // Write port kept free of reset so the array maps onto block RAM.
    always_ff @(posedge clock)
        if (push_ok && !flush && !reset) mem[wr_ptr] <= data_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            data_valid <= pop_ok;
            if (pop_ok) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
            end
            if (push_ok) wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            count     <= (push_ok && !pop_ok) ? count + 1'b1 :
                         (pop_ok && !push_ok) ? count - 1'b1 : count;
            overflow  <= overflow | (push && !push_ok);
            underflow <= underflow | (pop && !pop_ok);
        end
    end
endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: queue-based reference model with a scoreboard monitor, plus a large-depth fill/drain run.
module tb_fifo_buffer;
    localparam int DEPTH = 5;
    localparam int BIG   = 4900;

    logic       clock = 1'b0;
    logic       reset = 1'b1, flush = 1'b0, push = 1'b0, pop = 1'b0;
    logic [7:0] data_in = '0, data_out;
    logic [3:0] count;
    logic       data_valid, empty, full, almost_empty, almost_full, overflow, underflow;

    logic        b_push = 1'b0, b_pop = 1'b0;
    logic [7:0]  b_din = '0, b_dout;
    logic [13:0] b_count;
    logic        b_valid, b_empty, b_full, b_aempty, b_afull, b_ovf, b_udf;

    always #5 clock = ~clock;

    fifo_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .DEPTH(DEPTH), .AFULL_LEVEL(4), .AEMPTY_LEVEL(1)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .push(push), .pop(pop), .flush(flush),
        .data_out(data_out), .data_valid(data_valid), .count(count), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .overflow(overflow), .underflow(underflow));

    fifo_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(13), .DEPTH(BIG), .AFULL_LEVEL(4800), .AEMPTY_LEVEL(100)) dut_big (
        .clock(clock), .reset(reset), .data_in(b_din), .push(b_push), .pop(b_pop), .flush(1'b0),
        .data_out(b_dout), .data_valid(b_valid), .count(b_count), .empty(b_empty), .full(b_full),
        .almost_empty(b_aempty), .almost_full(b_afull), .overflow(b_ovf), .underflow(b_udf));

    int nchk = 0, nerr = 0;
    logic [7:0] mq[$];
    logic [7:0] sb[$];
    logic [7:0] m_dout = '0;
    logic m_valid = 1'b0, m_ovf = 1'b0, m_udf = 1'b0, mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            chk("count", int'(count), mq.size());
            chk("empty", int'(empty), int'(mq.size() == 0));
            chk("full", int'(full), int'(mq.size() == DEPTH));
            chk("almost_empty", int'(almost_empty), int'(mq.size() <= 1));
            chk("almost_full", int'(almost_full), int'(mq.size() >= 4));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("underflow", int'(underflow), int'(m_udf));
            chk("data_valid", int'(data_valid), int'(m_valid));
            chk("data_out_hold", int'(data_out), int'(m_dout));
            if (data_valid) begin
                if (sb.size() == 0) chk("scoreboard_empty", 1, 0);
                else chk("popped_word", int'(data_out), int'(sb.pop_front()));
            end
        end
    end

    task automatic cycle(input logic rs, input logic f, input logic p, input logic q, input logic [7:0] d);
        logic pok, wok;
        reset = rs; flush = f; push = p; pop = q; data_in = d;
        @(posedge clock);
        if (rs) begin
            mq.delete(); sb.delete();
            m_valid = 0; m_dout = '0; m_ovf = 0; m_udf = 0; mon_en = 1;
        end else if (f) begin
            mq.delete();
            m_valid = 0; m_ovf = 0; m_udf = 0;
        end else begin
            pok = q && mq.size() != 0;
            wok = p && (mq.size() != DEPTH || pok);
            m_ovf = m_ovf | (p && !wok);
            m_udf = m_udf | (q && !pok);
            m_valid = pok;
            if (pok) begin
                m_dout = mq.pop_front();
                sb.push_back(m_dout);
            end
            if (wok) mq.push_back(d);
        end
        @(negedge clock);
    endtask

    initial begin
        cycle(1, 0, 0, 0, 8'h00);
        cycle(1, 0, 0, 0, 8'h00);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 8'(8'h11 + i));
            for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 8'h00);
        end
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 0, 8'(8'h11 + i));
        cycle(0, 0, 1, 0, 8'hAA);
        cycle(0, 0, 1, 1, 8'hBB);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 8'h00);
        cycle(0, 0, 0, 1, 8'h00);
        cycle(0, 0, 1, 1, 8'h5A);
        cycle(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 8'(8'h30 + i));
        cycle(0, 1, 1, 0, 8'hCC);
        cycle(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, i[0], 8'(8'h40 + i));
        cycle(1, 0, 1, 1, 8'h99);
        cycle(0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 800; i++) begin
            logic heavy;
            heavy = ((i / 60) % 2) == 0;
            cycle($urandom_range(0, 149) == 0, $urandom_range(0, 79) == 0,
                  heavy ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0,
                  heavy ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0,
                  8'($urandom));
        end
        cycle(0, 0, 0, 0, 8'h00);
        cycle(0, 0, 0, 0, 8'h00);

        for (int i = 0; i < BIG; i++) begin
            b_push = 1; b_din = 8'(i);
            @(posedge clock); @(negedge clock);
        end
        b_push = 0;
        chk("big_count_full", int'(b_count), BIG);
        chk("big_full", int'(b_full), 1);
        chk("big_afull", int'(b_afull), 1);
        chk("big_overflow", int'(b_ovf), 0);
        for (int i = 0; i < BIG; i++) begin
            b_pop = 1;
            @(posedge clock); @(negedge clock);
            chk("big_valid", int'(b_valid), 1);
            chk("big_data", int'(b_dout), i % 256);
        end
        b_pop = 0;
        @(posedge clock); @(negedge clock);
        chk("big_valid_idle", int'(b_valid), 0);
        chk("big_empty", int'(b_empty), 1);
        chk("big_aempty", int'(b_aempty), 1);
        b_push = 1; b_din = 8'h77;
        @(posedge clock); @(negedge clock);
        b_push = 0; b_pop = 1;
        @(posedge clock); @(negedge clock);
        b_pop = 0;
        chk("big_wrap_data", int'(b_dout), 8'h77);
        chk("big_wrap_count", int'(b_count), 0);
        chk("big_overflow_end", int'(b_ovf), 0);
        chk("big_underflow_end", int'(b_udf), 0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule

// File: doc/fifo_buffer.md
# fifo_buffer

Parametrised synchronous FIFO, the next generation of the frame-buffer FIFO used between the pixel/data producers and consumers in the design. It supports an arbitrary, non-power-of-two depth with full-capacity use, single-cycle push and pop, and simultaneous push/pop at any fill level, including full. It adds an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. Storage is an inferred synchronous-read RAM inside the block.

## Interface
- DATA_WIDTH, 8: word width in bits.
- ADDR_WIDTH, 13: pointer width; must satisfy DEPTH <= 2^ADDR_WIDTH.
- DEPTH, 4900: number of storage words. All DEPTH words are usable.
- AFULL_LEVEL, 4800: almost_full asserts when count >= AFULL_LEVEL.
- AEMPTY_LEVEL, 100: almost_empty asserts when count <= AEMPTY_LEVEL.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  DATA_WIDTH  write data, sampled when a push is accepted.
- push  in  1  push request, one word per cycle.
- pop  in  1  pop request, one word per cycle.
- flush  in  1  synchronous clear of contents and error flags.
- data_out  out  DATA_WIDTH  registered read data.
- data_valid  out  1  one-cycle strobe marking data_out as a newly popped word.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty, almost_full  out  1 each  threshold flags as defined above.
- overflow, underflow  out  1 each  sticky error flags.

## Operation
- **Acceptance rules:**
  - pop_ok = pop && count != 0.
  - push_ok = push && (count != DEPTH || pop_ok).
- **Push accepted:** mem[wr_ptr] <= data_in; wr_ptr advances.
- **Pop accepted:** data_out <= mem[rd_ptr]; data_valid <= 1; rd_ptr advances.
- **No pop accepted:** data_valid <= 0 and data_out holds its value.
- **Pointer wrap:** a pointer at DEPTH-1 advances to 0, never to DEPTH. Wrap logic must not assume a power-of-two depth.
- **Count update:**
  - push_ok only: count + 1.
  - pop_ok only: count - 1.
  - Both or neither: unchanged.
- **Simultaneous push and pop:**
  - When full: both are accepted and count stays at DEPTH. wr_ptr == rd_ptr in this case, and the RAM is read-before-write, so data_out returns the old word.
  - When empty: the push is accepted, the pop is rejected, underflow sets, and count becomes 1.
- **Error flags:**
  - overflow sets when push && !push_ok.
  - underflow sets when pop && !pop_ok.
  - Both are sticky until reset or flush.
- **Flush:** pointers, count, data_valid, overflow and underflow go to 0. Flush has priority over push/pop in the same cycle; those requests are ignored and set no flags. data_out holds its value.
- **Reset:** pointers, count, data_out, data_valid, overflow and underflow go to 0. Reset overrides flush, push and pop, including mid-stream. RAM contents are not cleared.
- **State machine:** none beyond the pointer/count registers. There is no busy or multi-cycle state; every accepted request completes in one cycle.

## Timing
- **Push:** a push accepted at edge N is visible in count/empty/full after edge N. The word can be popped starting in cycle N+1.
- **Pop latency:** 1 cycle. With pop_ok sampled at edge N, data_out and data_valid are valid after edge N. data_valid is high for exactly one cycle per accepted pop.
- **Throughput:** one push and one pop per cycle, sustained indefinitely.
- **Status outputs:** empty, full, almost_* are combinational decodes of the registered count; no glitch-free requirement beyond that.
- **Values after reset:** data_out=0, data_valid=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.

## Test plan
Benches run with DATA_WIDTH=8, ADDR_WIDTH=3, DEPTH=5, AFULL_LEVEL=4, AEMPTY_LEVEL=1 unless noted.
- **Reset values:** assert reset for 2 cycles -> all outputs at the reset values above; empty=1, count=0.
- **Fill and drain with wrap:**
  - Push 0x11..0x15 -> count=5, full=1, almost_full=1 from count=4.
  - Pop 5 -> data_out 0x11..0x15 in order, each with a one-cycle data_valid; empty=1.
  - Repeat 3 times -> pointers wrap at 4->0 with data intact.
- **Full boundary:**
  - At full, push 0xAA alone -> overflow=1, count=5, contents unchanged.
  - Then push 0xBB with pop -> pop returns the oldest word, count=5, 0xBB is stored last.
- **Empty boundary:**
  - At empty, pop alone -> underflow=1, data_valid=0.
  - Push 0x5A with pop at empty -> count=1, underflow=1, next pop returns 0x5A.
- **Flush and reset mid-stream:**
  - With count=3, overflow=1, assert flush together with push -> next cycle count=0, overflow=0, nothing written.
  - Assert reset during a push/pop stream -> reset values next cycle.
- **Large-depth configuration:** DEPTH=4900, ADDR_WIDTH=13; push 4900 incrementing words, then pop all -> full=1 at 4900, pointer wraps 4899->0, order preserved, no overflow.
